// File: rtl/lfsr_rand_gen_if.sv
// Request/result bundle for lfsr_rand_gen: bounded-draw request in, bounded result out.
interface lfsr_rand_gen_if #(
    parameter int unsigned OUT_W = 8
);
    logic             req;
    logic [OUT_W-1:0] bound;
    logic             busy;
    logic [OUT_W-1:0] rnd;
    logic             rnd_valid;
    logic             rnd_fallback;

    modport master (
        output req, bound,
        input  busy, rnd, rnd_valid, rnd_fallback
    );

    modport slave (
        input  req, bound,
        output busy, rnd, rnd_valid, rnd_fallback
    );
endinterface

// File: rtl/lfsr_rand_gen.sv
// Fibonacci XNOR LFSR with seed load, free-run step and bounded draws by rejection sampling.
// Optional lockup recovery is enabled by defining LFSR_RAND_GEN_LOCKUP_RECOVER_EN.
module lfsr_rand_gen #(
    parameter int unsigned     WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'h100B,
    parameter logic [WIDTH-1:0] SEED     = 16'hAAAA,
    parameter int unsigned     OUT_W     = 8,
    parameter int unsigned     MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    lfsr_rand_gen_if.slave   bus,
    output logic [WIDTH-1:0] state,
    output logic             lockup_det
);
    localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < WIDTH; i++) n += 32'(v[i]);
        return n;
    endfunction

    // Even tap count means the XOR chain is inverted, making all-ones the lockup state.
    localparam logic FB_INV = ((popcount(TAPS) % 2) == 0);

    typedef enum logic {IDLE, DRAW} fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [OUT_W-1:0] bound_q;
    logic [TW-1:0]    tries;
    logic [OUT_W-1:0] cand;
    logic             fb;
    logic             start, accept, give_up, retry, step, recover;

    assign cand = state[OUT_W-1:0];
    assign fb   = (^(state & TAPS)) ^ FB_INV;
    assign bus.busy = (fsm == DRAW);

`ifdef LFSR_RAND_GEN_LOCKUP_RECOVER_EN
    assign recover = &state;
`else
    assign recover = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    // A load cycle inside DRAW evaluates no candidate, so the draw simply resumes afterwards.
    always_comb begin
        fsm_nxt = fsm;
        start   = 1'b0;
        accept  = 1'b0;
        give_up = 1'b0;
        retry   = 1'b0;
        step    = 1'b0;
        case (fsm)
            IDLE: begin
                step = en;
                if (bus.req && (bus.bound != '0)) begin
                    start   = 1'b1;
                    fsm_nxt = DRAW;
                end
            end
            DRAW: begin
                step = 1'b1;
                if (!load) begin
                    if (cand < bound_q) begin
                        accept  = 1'b1;
                        fsm_nxt = IDLE;
                    end else if (tries == TW'(MAX_TRIES - 1)) begin
                        give_up = 1'b1;
                        fsm_nxt = IDLE;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= SEED;
            bound_q          <= '0;
            tries            <= '0;
            bus.rnd          <= '0;
            bus.rnd_valid    <= 1'b0;
            bus.rnd_fallback <= 1'b0;
        end else begin
            bus.rnd_valid <= accept | give_up;
            if (accept) begin
                bus.rnd          <= cand;
                bus.rnd_fallback <= 1'b0;
            end else if (give_up) begin
                bus.rnd          <= '0;
                bus.rnd_fallback <= 1'b1;
            end

            if (start) begin
                bound_q <= bus.bound;
                tries   <= '0;
            end else if (retry) begin
                tries <= tries + 1'b1;
            end

            if (load)         state <= seed_in;
            else if (recover) state <= SEED;
            else if (step)    state <= {fb, state[WIDTH-1:1]};
        end
    end

`ifdef LFSR_RAND_GEN_LOCKUP_RECOVER_EN
    always_ff @(posedge clk) begin
        if (rst) lockup_det <= 1'b0;
        else     lockup_det <= recover && !load;
    end
`else
    assign lockup_det = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: expected draw results are queued at request time
// and popped by an independent monitor whenever rnd_valid is seen.
module tb_lfsr_rand_gen;
    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] seed_in;
    logic [15:0] state;
    logic        lockup_det;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0] rnd;
        logic       fallback;
    } exp_t;
    exp_t exp_q[$];

    lfsr_rand_gen_if #(.OUT_W(8)) bus ();

    lfsr_rand_gen #(
        .WIDTH(16), .TAPS(16'h100B), .SEED(16'hAAAA), .OUT_W(8), .MAX_TRIES(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .bus(bus.slave), .state(state), .lockup_det(lockup_det)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        vectors++;
        if (act !== req_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
        end
    endtask

    // Monitor: every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rnd_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rnd_valid: got rnd=%0d fallback=%0b, expected no result",
                         bus.rnd, bus.rnd_fallback);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.rnd !== e.rnd || bus.rnd_fallback !== e.fallback) begin
                    miscompares++;
                    $display("FAIL result: got rnd=%0d fallback=%0b, expected rnd=%0d fallback=%0b",
                             bus.rnd, bus.rnd_fallback, e.rnd, e.fallback);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
        bus.req = 1'b0; bus.bound = '0;

        // 1: reset values, then one free-run step
        tick; tick;
        rst = 1'b0;
        check("reset_state", 32'(state), 32'hAAAA);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_rnd", 32'(bus.rnd), 0);
        check("reset_valid", 32'(bus.rnd_valid), 0);
        check("reset_fallback", 32'(bus.rnd_fallback), 0);
        check("reset_lockup", 32'(lockup_det), 0);
        en = 1'b1; tick; en = 1'b0;
        check("step_state", 32'(state), 32'hD555);

        // 2: immediate accept, then back-to-back req while rnd_valid is high
        load = 1'b1; seed_in = 16'h0005; tick; load = 1'b0;
        check("load_state", 32'(state), 32'h0005);
        bus.req = 1'b1; bus.bound = 8'd20; exp_q.push_back('{rnd: 8'd5, fallback: 1'b0});
        tick; bus.req = 1'b0;
        check("t2_busy_1", 32'(bus.busy), 1);
        tick;
        check("t2_busy_0", 32'(bus.busy), 0);
        check("t2_valid", 32'(bus.rnd_valid), 1);
        check("t2_state_after_draw", 32'(state), 32'h0002);
        bus.req = 1'b1; exp_q.push_back('{rnd: 8'd2, fallback: 1'b0});
        tick; bus.req = 1'b0;
        check("t2_reaccept_busy", 32'(bus.busy), 1);
        check("t2_valid_pulse", 32'(bus.rnd_valid), 0);
        tick; tick;
        check("t2_valid_low", 32'(bus.rnd_valid), 0);
        check("t2_rnd_held", 32'(bus.rnd), 2);

        // 3: one rejection, then accept
        load = 1'b1; seed_in = 16'h0013; tick; load = 1'b0;
        bus.req = 1'b1; bus.bound = 8'd19; exp_q.push_back('{rnd: 8'd9, fallback: 1'b0});
        tick; bus.req = 1'b0;
        tick;
        check("t3_state_after_reject", 32'(state), 32'h8009);
        check("t3_busy_after_reject", 32'(bus.busy), 1);
        tick;
        check("t3_busy_done", 32'(bus.busy), 0);
        tick;

`ifndef LFSR_RAND_GEN_LOCKUP_RECOVER_EN
        // 4: stuck in all-ones, every candidate rejected until fallback
        load = 1'b1; seed_in = 16'hFFFF; tick; load = 1'b0;
        bus.req = 1'b1; bus.bound = 8'd10; exp_q.push_back('{rnd: 8'd0, fallback: 1'b1});
        tick; bus.req = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        check("t4_busy_cycles", 32'(n), 16);
        check("t4_state_stuck", 32'(state), 32'hFFFF);
        check("t4_lockup_tied", 32'(lockup_det), 0);
        tick;
`else
        // 5: lockup recovery restores SEED with a single detect pulse
        load = 1'b1; seed_in = 16'hFFFF; tick; load = 1'b0;
        en = 1'b1; tick; en = 1'b0;
        check("t5_recover_state", 32'(state), 32'hAAAA);
        check("t5_lockup_pulse", 32'(lockup_det), 1);
        tick;
        check("t5_lockup_low", 32'(lockup_det), 0);
`endif

        // 6: bound==0 ignored; reset mid-draw aborts with no result
        bus.req = 1'b1; bus.bound = 8'd0; tick; bus.req = 1'b0;
        check("t6_bound0_busy", 32'(bus.busy), 0);
        tick;
        check("t6_bound0_busy_later", 32'(bus.busy), 0);
        load = 1'b1; seed_in = 16'h00FF; tick; load = 1'b0;
        bus.req = 1'b1; bus.bound = 8'd1; tick; bus.req = 1'b0;
        tick;
        check("t6_mid_draw_busy", 32'(bus.busy), 1);
        check("t6_mid_draw_state", 32'(state), 32'h007F);
        rst = 1'b1; tick; rst = 1'b0;
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_state", 32'(state), 32'hAAAA);
        tick; tick; tick;

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
